cv32e40p_instr_obi_fetch: RTL and testbench



---
 rtl/cv32e40p_instr_obi_fetch.sv | 158 +++++++++++++++
 tb/tb_cv32e40p_instr_obi_fetch.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cv32e40p_instr_obi_fetch.sv
// rtl/cv32e40p_instr_obi_fetch.sv - OBI instruction fetch front end with response FIFO and branch flush
// Optional: CV32E40P_FETCH_ERR_EN stores instr_err_i per entry and drives fetch_err_o.
module cv32e40p_instr_obi_fetch #(
    parameter int DEPTH           = 2,
    parameter int MAX_OUTSTANDING = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_i,
    input  logic        branch_i,
    input  logic [31:0] branch_addr_i,
    input  logic        fetch_ready_i,
    output logic        fetch_valid_o,
    output logic [31:0] fetch_rdata_o,
    output logic        fetch_err_o,
    output logic        instr_req_o,
    output logic [31:0] instr_addr_o,
    input  logic        instr_gnt_i,
    input  logic        instr_rvalid_i,
    input  logic [31:0] instr_rdata_i,
    input  logic        instr_err_i,
    output logic        busy_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int OW = $clog2(MAX_OUTSTANDING + 1);

    typedef enum logic [1:0] {IDLE, REQ, REQ_BRPEND} state_t;

    state_t        state, state_nxt;
    logic [31:0]   next_addr, next_addr_nxt;
    logic [31:0]   br_addr, br_addr_nxt;
    logic [31:0]   branch_tgt;
    logic [OW-1:0] outstanding, out_nxt;
    logic [OW-1:0] discard_cnt, discard_nxt;
    logic [CW-1:0] fifo_cnt, fifo_cnt_nxt;
    logic [CW:0]   space_used;
    logic [AW-1:0] wptr, rptr;
    logic [31:0]   data_q [DEPTH];
    logic          gnt_fire, push, pop, issue_ok;

    assign branch_tgt  = {branch_addr_i[31:2], 2'b00};
    assign instr_req_o = (state != IDLE);
    assign gnt_fire    = instr_req_o & instr_gnt_i;
    assign busy_o      = instr_req_o | (outstanding != '0);

    // Responses owed to a killed stream are dropped; the branch cycle drops its own rvalid too.
    assign push = instr_rvalid_i & ~branch_i & (discard_cnt == '0);
    assign pop  = fetch_valid_o & fetch_ready_i & ~branch_i;

    // Issue decision looks at next-cycle occupancy so every in-flight response has a slot.
    always_comb begin
        out_nxt      = outstanding + OW'(gnt_fire) - OW'(instr_rvalid_i);
        fifo_cnt_nxt = branch_i ? '0 : fifo_cnt + CW'(push) - CW'(pop);
        space_used   = (CW+1)'(fifo_cnt_nxt) + (CW+1)'(out_nxt);
        issue_ok     = req_i & (out_nxt < OW'(MAX_OUTSTANDING))
                     & (space_used < (CW+1)'(DEPTH));
        if (branch_i) begin
            discard_nxt = out_nxt;
        end else begin
            discard_nxt = discard_cnt
                        - OW'(instr_rvalid_i && (discard_cnt != '0))
                        + OW'((state == REQ_BRPEND) && instr_gnt_i);
        end
    end

    always_comb begin
        state_nxt     = state;
        next_addr_nxt = next_addr;
        br_addr_nxt   = br_addr;
        instr_addr_o  = next_addr;
        case (state)
            IDLE: begin
                if (branch_i) begin
                    instr_addr_o  = branch_tgt;
                    next_addr_nxt = branch_tgt;
                end
                if (issue_ok) state_nxt = REQ;
            end
            REQ: begin
                if (instr_gnt_i) begin
                    next_addr_nxt = branch_i ? branch_tgt : next_addr + 32'd4;
                    state_nxt     = issue_ok ? REQ : IDLE;
                end else if (branch_i) begin
                    br_addr_nxt = branch_tgt;
                    state_nxt   = REQ_BRPEND;
                end
            end
            REQ_BRPEND: begin
                // The held request belongs to the old stream; its grant is never counted as live.
                if (instr_gnt_i) begin
                    next_addr_nxt = branch_i ? branch_tgt : br_addr;
                    state_nxt     = issue_ok ? REQ : IDLE;
                end else if (branch_i) begin
                    br_addr_nxt = branch_tgt;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            next_addr   <= '0;
            br_addr     <= '0;
            outstanding <= '0;
            discard_cnt <= '0;
            fifo_cnt    <= '0;
            wptr        <= '0;
            rptr        <= '0;
        end else begin
            state       <= state_nxt;
            next_addr   <= next_addr_nxt;
            br_addr     <= br_addr_nxt;
            outstanding <= out_nxt;
            discard_cnt <= discard_nxt;
            fifo_cnt    <= fifo_cnt_nxt;
            if (branch_i) begin
                wptr <= '0;
                rptr <= '0;
            end else begin
                if (push) wptr <= wptr + AW'(1);
                if (pop)  rptr <= rptr + AW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) data_q[wptr] <= instr_rdata_i;
    end

    assign fetch_valid_o = (fifo_cnt != '0);
    assign fetch_rdata_o = fetch_valid_o ? data_q[rptr] : '0;

`ifdef CV32E40P_FETCH_ERR_EN
    logic err_q [DEPTH];
    logic unused_sig;

    always_ff @(posedge clk) begin
        if (push) err_q[wptr] <= instr_err_i;
    end

    assign fetch_err_o = fetch_valid_o & err_q[rptr];
    assign unused_sig  = ^branch_addr_i[1:0];
`else
    logic unused_sig;

    assign fetch_err_o = 1'b0;
    assign unused_sig  = ^{branch_addr_i[1:0], instr_err_i};
`endif

    assert property (@(posedge clk) disable iff (!rst_n)
        instr_rvalid_i |-> (outstanding != '0));
    assert property (@(posedge clk) disable iff (!rst_n)
        (push && (fifo_cnt == CW'(DEPTH))) |-> pop);

endmodule

// File: tb/tb_cv32e40p_instr_obi_fetch.sv
// tb/tb_cv32e40p_instr_obi_fetch.sv - self-checking bench for cv32e40p_instr_obi_fetch
module tb_cv32e40p_instr_obi_fetch;
    localparam int DEPTH = 2;
    localparam int MAXO  = 2;
`ifdef CV32E40P_FETCH_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic        clk, rst_n;
    logic        req_i, branch_i, fetch_ready_i;
    logic [31:0] branch_addr_i;
    logic        fetch_valid_o, fetch_err_o, instr_req_o, busy_o;
    logic [31:0] fetch_rdata_o, instr_addr_o;
    logic        instr_gnt_i, instr_rvalid_i, instr_err_i;
    logic [31:0] instr_rdata_i;

    int passed = 0;
    int total  = 0;

    cv32e40p_instr_obi_fetch #(.DEPTH(DEPTH), .MAX_OUTSTANDING(MAXO)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .req_i          (req_i),
        .branch_i       (branch_i),
        .branch_addr_i  (branch_addr_i),
        .fetch_ready_i  (fetch_ready_i),
        .fetch_valid_o  (fetch_valid_o),
        .fetch_rdata_o  (fetch_rdata_o),
        .fetch_err_o    (fetch_err_o),
        .instr_req_o    (instr_req_o),
        .instr_addr_o   (instr_addr_o),
        .instr_gnt_i    (instr_gnt_i),
        .instr_rvalid_i (instr_rvalid_i),
        .instr_rdata_i  (instr_rdata_i),
        .instr_err_i    (instr_err_i),
        .busy_o         (busy_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        req, br;
        logic [31:0] baddr;
        logic        gnt, rv;
        logic [31:0] rdata;
        logic        rdy;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_valid;
        logic [31:0] e_rdata;
        logic        e_busy;
    } vec_t;

    typedef struct {
        int          epoch;
        logic [31:0] data;
        logic        err;
    } infl_t;

    typedef struct {
        logic [31:0] data;
        logic        err;
    } exp_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) $display("FAIL %s actual=%h required=%h", name, act, req);
        else passed++;
    endtask

    task automatic cyc(input logic rq, input logic br, input logic [31:0] ba, input logic g,
                       input logic rv, input logic [31:0] rd, input logic er, input logic rdy);
        @(negedge clk);
        req_i = rq; branch_i = br; branch_addr_i = ba; instr_gnt_i = g;
        instr_rvalid_i = rv; instr_rdata_i = rd; instr_err_i = er; fetch_ready_i = rdy;
        #1;
    endtask

    function automatic vec_t mk(input logic rq, input logic br, input logic [31:0] ba,
                                input logic g, input logic rv, input logic [31:0] rd,
                                input logic rdy, input logic erq, input logic [31:0] ead,
                                input logic ev, input logic [31:0] erd, input logic eb);
        vec_t v;
        v.req = rq; v.br = br; v.baddr = ba; v.gnt = g; v.rv = rv; v.rdata = rd; v.rdy = rdy;
        v.e_req = erq; v.e_addr = ead; v.e_valid = ev; v.e_rdata = erd; v.e_busy = eb;
        return v;
    endfunction

    vec_t        tbl [21];
    infl_t       infl [$];
    exp_t        expq [$];
    infl_t       it;
    exp_t        ex;
    int          epoch, req_epoch;
    logic [31:0] exp_addr, req_addr;
    bit          pending;
    logic        r_br, r_rdy, r_g, r_rv;
    logic [31:0] r_ba;

    initial begin
        // Boot from 0x82, then backpressure with ready held low.
        tbl[0]  = mk(1,1,32'h82,1,0,0,1,              0,32'h80,0,0,0);
        tbl[1]  = mk(1,0,0,1,0,0,1,                   1,32'h80,0,0,1);
        tbl[2]  = mk(1,0,0,1,1,32'h1000_0000,1,       1,32'h84,0,0,1);
        tbl[3]  = mk(1,0,0,1,1,32'h1000_0001,1,       0,32'h88,1,32'h1000_0000,1);
        tbl[4]  = mk(1,0,0,1,0,0,1,                   1,32'h88,1,32'h1000_0001,1);
        tbl[5]  = mk(1,0,0,1,1,32'h1000_0002,1,       1,32'h8C,0,0,1);
        tbl[6]  = mk(0,0,0,0,1,32'h1000_0003,1,       0,32'h90,1,32'h1000_0002,1);
        tbl[7]  = mk(0,0,0,0,0,0,1,                   0,32'h90,1,32'h1000_0003,0);
        tbl[8]  = mk(1,0,0,1,0,0,0,                   0,32'h90,0,0,0);
        tbl[9]  = mk(1,0,0,1,0,0,0,                   1,32'h90,0,0,1);
        tbl[10] = mk(1,0,0,1,1,32'h1000_0004,0,       1,32'h94,0,0,1);
        tbl[11] = mk(1,0,0,1,1,32'h1000_0005,0,       0,32'h98,1,32'h1000_0004,1);
        tbl[12] = mk(1,0,0,1,0,0,0,                   0,32'h98,1,32'h1000_0004,0);
        tbl[13] = mk(1,0,0,1,0,0,0,                   0,32'h98,1,32'h1000_0004,0);
        tbl[14] = mk(1,0,0,1,0,0,1,                   0,32'h98,1,32'h1000_0004,0);
        tbl[15] = mk(1,0,0,1,0,0,0,                   1,32'h98,1,32'h1000_0005,1);
        tbl[16] = mk(1,0,0,1,1,32'h1000_0006,0,       0,32'h9C,1,32'h1000_0005,1);
        tbl[17] = mk(0,0,0,0,0,0,0,                   0,32'h9C,1,32'h1000_0005,0);
        tbl[18] = mk(0,0,0,0,0,0,1,                   0,32'h9C,1,32'h1000_0005,0);
        tbl[19] = mk(0,0,0,0,0,0,1,                   0,32'h9C,1,32'h1000_0006,0);
        tbl[20] = mk(0,0,0,0,0,0,0,                   0,32'h9C,0,0,0);

        rst_n = 1'b0;
        req_i = 0; branch_i = 0; branch_addr_i = 0; fetch_ready_i = 0;
        instr_gnt_i = 0; instr_rvalid_i = 0; instr_rdata_i = 0; instr_err_i = 0;
        repeat (3) @(negedge clk);
        chk("rst_req", instr_req_o, 0);
        chk("rst_addr", instr_addr_o, 0);
        chk("rst_valid", fetch_valid_o, 0);
        chk("rst_rdata", fetch_rdata_o, 0);
        chk("rst_err", fetch_err_o, 0);
        chk("rst_busy", busy_o, 0);
        rst_n = 1'b1;

        for (int i = 0; i < 21; i++) begin
            cyc(tbl[i].req, tbl[i].br, tbl[i].baddr, tbl[i].gnt, tbl[i].rv,
                tbl[i].rdata, 1'b0, tbl[i].rdy);
            chk($sformatf("vec%0d_req", i), instr_req_o, tbl[i].e_req);
            chk($sformatf("vec%0d_addr", i), instr_addr_o, tbl[i].e_addr);
            chk($sformatf("vec%0d_valid", i), fetch_valid_o, tbl[i].e_valid);
            chk($sformatf("vec%0d_rdata", i), fetch_rdata_o, tbl[i].e_rdata);
            chk($sformatf("vec%0d_busy", i), busy_o, tbl[i].e_busy);
        end

        // Flush with two responses in flight.
        cyc(1,1,32'h10,0,0,0,0,1);
        cyc(1,0,0,1,0,0,0,1);
        cyc(1,0,0,1,0,0,0,1);
        cyc(1,1,32'h200,0,0,0,0,1);
        chk("fl_req_idle", instr_req_o, 0);
        chk("fl_busy", busy_o, 1);
        cyc(1,0,0,0,1,32'hBAD0,0,1);
        chk("fl_drop1_valid", fetch_valid_o, 0);
        cyc(1,0,0,1,1,32'hBAD1,0,1);
        chk("fl_new_addr", instr_addr_o, 32'h200);
        chk("fl_new_req", instr_req_o, 1);
        chk("fl_drop2_valid", fetch_valid_o, 0);
        cyc(1,0,0,0,1,32'h1200,0,1);
        chk("fl_drop3_valid", fetch_valid_o, 0);
        chk("fl_addr2", instr_addr_o, 32'h204);
        cyc(0,0,0,1,0,0,0,1);
        chk("fl_first_valid", fetch_valid_o, 1);
        chk("fl_first_data", fetch_rdata_o, 32'h1200);
        cyc(0,0,0,0,1,32'h1204,0,1);
        chk("fl_req_off", instr_req_o, 0);
        cyc(0,0,0,0,0,0,0,1);
        chk("fl_second_data", fetch_rdata_o, 32'h1204);
        cyc(0,0,0,0,0,0,0,1);
        chk("fl_empty", fetch_valid_o, 0);

        // Branch arriving while a request waits for grant.
        cyc(1,1,32'h40,0,0,0,0,1);
        cyc(1,1,32'h100,0,0,0,0,1);
        chk("bp_addr_c1", instr_addr_o, 32'h40);
        cyc(1,0,0,0,0,0,0,1);
        chk("bp_addr_c2", instr_addr_o, 32'h40);
        chk("bp_req_c2", instr_req_o, 1);
        cyc(1,0,0,1,0,0,0,1);
        chk("bp_addr_c3", instr_addr_o, 32'h40);
        cyc(1,0,0,0,1,32'hBAD40,0,1);
        chk("bp_new_addr", instr_addr_o, 32'h100);
        cyc(0,0,0,1,0,0,0,1);
        chk("bp_drop_valid", fetch_valid_o, 0);
        cyc(0,0,0,0,1,32'h5100,0,1);
        chk("bp_req_off", instr_req_o, 0);
        cyc(0,0,0,0,0,0,0,1);
        chk("bp_data", fetch_rdata_o, 32'h5100);
        cyc(0,0,0,0,0,0,0,1);
        chk("bp_empty", fetch_valid_o, 0);
        chk("bp_idle", busy_o, 0);

        // Branch coinciding with rvalid and a pop.
        cyc(1,1,32'h300,0,0,0,0,0);
        cyc(1,0,0,1,0,0,0,0);
        cyc(1,0,0,1,1,32'hA300,0,0);
        cyc(1,1,32'h400,0,1,32'hA304,0,1);
        chk("sim_pre_valid", fetch_valid_o, 1);
        chk("sim_pre_data", fetch_rdata_o, 32'hA300);
        cyc(0,0,0,1,0,0,0,1);
        chk("sim_flushed", fetch_valid_o, 0);
        chk("sim_new_addr", instr_addr_o, 32'h400);
        cyc(0,0,0,0,1,32'hA400,0,1);
        chk("sim_no_stale", fetch_valid_o, 0);
        cyc(0,0,0,0,0,0,0,1);
        chk("sim_new_data", fetch_rdata_o, 32'hA400);
        cyc(0,0,0,0,0,0,0,1);
        chk("sim_empty", fetch_valid_o, 0);

        // Error-tagged response followed by a clean one.
        cyc(1,1,32'h500,0,0,0,0,0);
        cyc(1,0,0,1,0,0,0,0);
        cyc(1,0,0,1,1,32'hDEADBEEF,1,0);
        cyc(0,0,0,0,1,32'h600,0,0);
        chk("err_data", fetch_rdata_o, 32'hDEADBEEF);
        chk("err_flag", fetch_err_o, ERR_EN);
        cyc(0,0,0,0,0,0,0,1);
        chk("err_flag_hold", fetch_err_o, ERR_EN);
        cyc(0,0,0,0,0,0,0,1);
        chk("err_next_data", fetch_rdata_o, 32'h600);
        chk("err_next_flag", fetch_err_o, 0);
        cyc(0,0,0,0,0,0,0,0);
        chk("err_empty", fetch_valid_o, 0);

        // Randomized traffic against a stream/epoch scoreboard.
        epoch = 0; req_epoch = 0; pending = 0; exp_addr = 0; req_addr = 0;
        for (int k = 0; k < 3000; k++) begin
            r_br  = (k == 0) || ($urandom_range(15) == 0);
            r_ba  = $urandom;
            r_rdy = 1'($urandom_range(1));
            r_g   = 1'($urandom_range(1));
            r_rv  = (infl.size() != 0) && ($urandom_range(1) == 1);
            if (r_rv) cyc(($urandom_range(7) != 0), r_br, r_ba, r_g, 1'b1,
                          infl[0].data, infl[0].err, r_rdy);
            else      cyc(($urandom_range(7) != 0), r_br, r_ba, r_g, 1'b0,
                          $urandom, 1'($urandom_range(1)), r_rdy);

            chk("rnd_valid", fetch_valid_o, (expq.size() != 0));
            if (expq.size() != 0) begin
                chk("rnd_data", fetch_rdata_o, expq[0].data);
                chk("rnd_err", fetch_err_o, ERR_EN & expq[0].err);
            end
            chk("rnd_busy", busy_o, instr_req_o | (infl.size() != 0));
            if (pending) begin
                chk("rnd_req_held", instr_req_o, 1);
                chk("rnd_addr_held", instr_addr_o, req_addr);
            end else if (instr_req_o) begin
                req_epoch = epoch;
                req_addr  = instr_addr_o;
            end

            if (r_rdy && !r_br && expq.size() != 0) void'(expq.pop_front());
            if (r_rv) begin
                it = infl.pop_front();
                if (!r_br && it.epoch == epoch) begin
                    ex.data = it.data;
                    ex.err  = it.err;
                    expq.push_back(ex);
                end
            end
            if (instr_req_o && r_g) begin
                if (req_epoch == epoch && !r_br) begin
                    chk("rnd_addr", instr_addr_o, exp_addr);
                    exp_addr = exp_addr + 32'd4;
                end
                it.epoch = req_epoch;
                it.data  = $urandom;
                it.err   = 1'($urandom_range(1));
                infl.push_back(it);
            end
            if (r_br) begin
                expq.delete();
                epoch++;
                exp_addr = {r_ba[31:2], 2'b00};
            end
            chk("rnd_outstanding", (infl.size() <= MAXO), 1);
            chk("rnd_space", (expq.size() + infl.size() <= DEPTH), 1);
            pending = instr_req_o && !r_g;
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
